fixed_multiply_module: RTL and testbench

- Sequential signed fixed-point multiplier; computes product = multiplicand × multiplier in Q(D_BITS−Q_BITS).Q_BITS format.
- Datapath companion to the team's iterative fixed-point divider. Uses the same FIFO-style handshake: read from an input FIFO, write to an output FIFO.
- Shift-and-add on magnitudes; result is rounded and saturated to D_BITS.

---
 rtl/fixed_multiply_module.sv | 100 ++++++++++
 tb/tb_fixed_multiply_module.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_multiply_module.sv
// Sequential signed fixed-point multiplier: shift-and-add on magnitudes, then round and saturate.
// FIFO-style handshake: pops operands from an input FIFO and pushes the result to an output FIFO.
module fixed_multiply_module #(
    parameter int Q_BITS = 10,
    parameter int D_BITS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [D_BITS-1:0] multiplicand,
    input  logic [D_BITS-1:0] multiplier,
    input  logic              in_empty,
    output logic              in_rd_en,
    output logic [D_BITS-1:0] product,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic              overflow
);

    localparam int PW = 2 * D_BITS + 1;
    localparam int CW = $clog2(D_BITS) + 1;

    typedef enum logic [1:0] {IDLE, MUL, ROUND, WRITE} state_t;

    state_t            state;
    logic [D_BITS-1:0] m_reg;
    logic [D_BITS-1:0] q_reg;
    logic [D_BITS:0]   acc;
    logic [CW-1:0]     count;
    logic              sign;
    logic [D_BITS-1:0] result;

    logic [D_BITS-1:0] abs_a;
    logic [D_BITS-1:0] abs_b;
    logic [D_BITS:0]   acc_sum;
    logic [PW-1:0]     rounded;
    logic [PW-1:0]     limit;
    logic [PW-1:0]     sat;
    logic              ovf_c;
    logic [D_BITS-1:0] result_next;

    always_comb begin
        abs_a   = multiplicand[D_BITS-1] ? ('0 - multiplicand) : multiplicand;
        abs_b   = multiplier[D_BITS-1]   ? ('0 - multiplier)   : multiplier;
        acc_sum = acc + (q_reg[0] ? {1'b0, m_reg} : '0);

        // {acc, q_reg} is the full magnitude product once MUL completes
        rounded = ({acc, q_reg} + (PW'(1) << (Q_BITS - 1))) >> Q_BITS;
        limit   = sign ? (PW'(1) << (D_BITS - 1))
                       : ((PW'(1) << (D_BITS - 1)) - PW'(1));
        ovf_c   = rounded > limit;
        sat     = ovf_c ? limit : rounded;
        result_next = sign ? ('0 - sat[D_BITS-1:0]) : sat[D_BITS-1:0];

        in_rd_en  = (state == IDLE) && !in_empty;
        out_wr_en = (state == WRITE) && !out_full;
        product   = out_wr_en ? result : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            m_reg    <= '0;
            q_reg    <= '0;
            acc      <= '0;
            count    <= '0;
            sign     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_empty) begin
                        m_reg <= abs_a;
                        q_reg <= abs_b;
                        sign  <= multiplicand[D_BITS-1] ^ multiplier[D_BITS-1];
                        acc   <= '0;
                        count <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc   <= {1'b0, acc_sum[D_BITS:1]};
                    q_reg <= {acc_sum[0], q_reg[D_BITS-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(D_BITS - 1)) state <= ROUND;
                end
                ROUND: begin
                    result   <= result_next;
                    overflow <= ovf_c;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (!out_full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_multiply_module.sv
// Scoreboard bench for fixed_multiply_module: directed corner cases, back-pressure,
// reset mid-operation and randomized operands against an arithmetic reference model.
module tb_fixed_multiply_module;

    localparam int QB  = 10;
    localparam int DB  = 32;
    localparam int LAT = DB + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] multiplicand = '0;
    logic [DB-1:0] multiplier = '0;
    logic          in_empty = 1'b1;
    logic          in_rd_en;
    logic [DB-1:0] product;
    logic          out_wr_en;
    logic          out_full = 1'b0;
    logic          overflow;

    fixed_multiply_module #(.Q_BITS(QB), .D_BITS(DB)) dut (
        .clock(clock),
        .reset(reset),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .product(product),
        .out_wr_en(out_wr_en),
        .out_full(out_full),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DB-1:0] a;
        logic [DB-1:0] b;
    } op_t;

    typedef struct {
        logic [DB-1:0] prod;
        logic          ovf;
        int            acc_cyc;
        int            lat;
    } exp_t;

    op_t  in_q[$];
    exp_t sb[$];
    exp_t mon_e;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int lat_next = LAT;
    bit chk_follow = 1'b0;
    int last_wr_cyc = -100;
    bit rd_flag = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Real-number view: |A|*|B| scaled by 2^-Q, rounded half away from zero, clamped to D bits
    function automatic exp_t model(input logic [DB-1:0] a, input logic [DB-1:0] b,
                                   input int acc_c, input int lat);
        longint sa, sb2, ma, mb, r, v;
        exp_t e;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb2 < 0) ? -sb2 : sb2;
        r   = (ma * mb + (64'sd1 <<< (QB - 1))) / (64'sd1 <<< QB);
        v   = ((sa < 0) != (sb2 < 0)) ? -r : r;
        e.ovf = 1'b0;
        if (v > 64'sd2147483647) begin
            v = 64'sd2147483647;
            e.ovf = 1'b1;
        end else if (v < -64'sd2147483648) begin
            v = -64'sd2147483648;
            e.ovf = 1'b1;
        end
        e.prod    = v[DB-1:0];
        e.acc_cyc = acc_c;
        e.lat     = lat;
        return e;
    endfunction

    task automatic refresh();
        in_empty = (in_q.size() == 0);
        if (in_q.size() != 0) begin
            multiplicand = in_q[0].a;
            multiplier   = in_q[0].b;
        end else begin
            multiplicand = '0;
            multiplier   = '0;
        end
    endtask

    task automatic enqueue(input logic [DB-1:0] a, input logic [DB-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        in_q.push_back(o);
        refresh();
    endtask

    // Monitor: compare writes against the scoreboard, record accepted operands
    always @(negedge clock) begin
        if (out_wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("product", longint'($signed(product)), longint'($signed(mon_e.prod)));
                check("overflow", longint'(overflow), longint'(mon_e.ovf));
                check("latency", cyc - mon_e.acc_cyc, mon_e.lat);
                last_wr_cyc = cyc;
            end
        end else begin
            check("product_zero_when_idle", longint'(product), 0);
        end
        if (in_rd_en) begin
            check("read_while_pending", sb.size(), 0);
            if (in_q.size() == 0) begin
                check("read_while_empty", 1, 0);
            end else begin
                if (chk_follow) begin
                    check("read_after_write", cyc - last_wr_cyc, 1);
                    chk_follow = 1'b0;
                end
                sb.push_back(model(in_q[0].a, in_q[0].b, cyc, lat_next));
                lat_next = LAT;
                rd_flag  = 1'b1;
            end
        end
    end

    // Input FIFO pops after the edge that consumed the head
    always @(posedge clock) begin
        #1;
        if (rd_flag) begin
            rd_flag = 1'b0;
            in_q.delete(0);
            refresh();
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20000; i++) begin
            @(posedge clock);
            #2;
            if (in_q.size() == 0 && sb.size() == 0) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic wait_accept(output int acc_c);
        acc_c = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #2;
            if (sb.size() != 0) begin
                acc_c = sb[0].acc_cyc;
                return;
            end
        end
        check("accept_timeout", 1, 0);
    endtask

    task automatic wait_cycle(input int target);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (cyc >= target) return;
        end
        check("cycle_wait_timeout", 1, 0);
    endtask

    initial begin
        int acc_c;
        logic [DB-1:0] ra, rb;

        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("reset_in_rd_en", longint'(in_rd_en), 0);
        check("reset_out_wr_en", longint'(out_wr_en), 0);
        check("reset_product", longint'(product), 0);
        check("reset_overflow", longint'(overflow), 0);

        @(posedge clock);
        #2;
        enqueue(32'd1536, 32'd2048);
        enqueue(-32'sd1536, 32'd2048);
        enqueue(32'd1, 32'd512);
        enqueue(-32'sd1, 32'd512);
        enqueue(32'd1, 32'd511);
        enqueue(32'h4000_0000, 32'h4000_0000);
        enqueue(32'hC000_0000, 32'h4000_0000);
        enqueue(32'd1024, 32'd1024);
        enqueue(32'h8000_0000, 32'd1024);
        enqueue(32'h8000_0000, -32'sd1024);
        enqueue(32'h8000_0000, 32'h8000_0000);
        enqueue(32'd0, 32'h8000_0000);
        enqueue(-32'sd5, 32'd0);
        enqueue(-32'sd1, 32'd511);
        wait_drain();

        // Back-pressure: output FIFO full for the first five WRITE cycles
        out_full = 1'b1;
        lat_next = LAT + 5;
        enqueue(32'd1536, -32'sd2048);
        enqueue(32'd3, 32'd4096);
        wait_accept(acc_c);
        chk_follow = 1'b1;
        wait_cycle(acc_c + LAT + 5);
        out_full = 1'b0;
        wait_drain();

        // Reset during MUL discards the in-flight operation
        enqueue(32'd7168, 32'd3072);
        enqueue(32'd2048, 32'd2048);
        wait_accept(acc_c);
        wait_cycle(acc_c + 10);
        reset = 1'b1;
        #1 reset = 1'b0;
        sb.delete(0);
        wait_drain();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ra = $urandom;
                    rb = $urandom;
                end
                1: begin
                    ra = DB'($signed($urandom_range(0, 2097151)) - 1048576);
                    rb = DB'($signed($urandom_range(0, 2097151)) - 1048576);
                end
                default: begin
                    ra = $urandom;
                    rb = DB'($signed($urandom_range(0, 8191)) - 4096);
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 40)) @(posedge clock);
                #2;
            end
            enqueue(ra, rb);
        end
        wait_drain();

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
